// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS instruction-format constants shared by the loader's encoder and the
// core's control-unit decoder, plus the symbolic instruction-kind enumeration and the
// loader FSM state type.
// Configuration: MIPS_LOADER_NOP_PAD_EN adds the StPad state used for NOP padding.
package mips_isa_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // R-type function codes, instruction bits [5:0]
    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    // Symbolic instruction kinds; codes 10..15 are illegal
    typedef enum logic [3:0] {
        KindAdd  = 4'd0,
        KindSub  = 4'd1,
        KindAnd  = 4'd2,
        KindOr   = 4'd3,
        KindSlt  = 4'd4,
        KindLw   = 4'd5,
        KindSw   = 4'd6,
        KindBeq  = 4'd7,
        KindAddi = 4'd8,
        KindJ    = 4'd9
    } instr_kind_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
`ifdef MIPS_LOADER_NOP_PAD_EN
        StPad  = 2'd2,
`endif
        StDone = 2'd3
    } loader_state_e;

    function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                           logic [5:0] funct);
        return {OpRType, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                           logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_encode.sv
// mips_instr_encode: purely combinational encoder from a symbolic instruction to a 32-bit
// MIPS machine word.
// Ports:
//   kind_i     instruction kind (see instr_kind_e)
//   rs_i/rt_i/rd_i  register fields
//   imm_i      imm16 in [15:0] for I-type, 26-bit target for J
//   word_o     encoded word (0 when illegal)
//   illegal_o  kind is not a defined instruction
module mips_instr_encode
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [25:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (kind_i)
            KindAdd:  word_o = r_word(rs_i, rt_i, rd_i, FunctAdd);
            KindSub:  word_o = r_word(rs_i, rt_i, rd_i, FunctSub);
            KindAnd:  word_o = r_word(rs_i, rt_i, rd_i, FunctAnd);
            KindOr:   word_o = r_word(rs_i, rt_i, rd_i, FunctOr);
            KindSlt:  word_o = r_word(rs_i, rt_i, rd_i, FunctSlt);
            KindLw:   word_o = i_word(OpLw, rs_i, rt_i, imm_i[15:0]);
            KindSw:   word_o = i_word(OpSw, rs_i, rt_i, imm_i[15:0]);
            KindBeq:  word_o = i_word(OpBeq, rs_i, rt_i, imm_i[15:0]);
            KindAddi: word_o = i_word(OpAddi, rs_i, rt_i, imm_i[15:0]);
            KindJ:    word_o = {OpJ, imm_i};
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_loader.sv
// mips_instr_loader: accepts symbolic instructions over valid/ready, encodes them and writes
// the words to consecutive instruction-memory addresses from 0.
// Configuration: define MIPS_LOADER_NOP_PAD_EN to fill the rest of memory with NOPs after
// the last instruction.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i              begin a session (honoured in idle/done only)
//   in_*_i, in_ready_o   instruction handshake and fields
//   imem_we_o/addr_o/wdata_o  registered memory write port
//   count_o              words written this session
//   done_o               session complete; err_o sticky illegal-kind flag
module mips_instr_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [3:0]            in_kind_i,
    input  logic [4:0]            in_rs_i,
    input  logic [4:0]            in_rt_i,
    input  logic [4:0]            in_rd_i,
    input  logic [25:0]           in_imm_i,
    input  logic                  in_last_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [DATA_WIDTH-1:0] imem_wdata_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [ADDR_WIDTH:0] LastAddr = {1'b0, {ADDR_WIDTH{1'b1}}};

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        full;
    logic        transfer;

    mips_instr_encode u_encode (
        .kind_i    (in_kind_i),
        .rs_i      (in_rs_i),
        .rt_i      (in_rt_i),
        .rd_i      (in_rd_i),
        .imm_i     (in_imm_i),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    // Count reaches 2^ADDR_WIDTH only once the top address has been written.
    assign full       = count_q[ADDR_WIDTH];
    assign in_ready_o = (state_q == StLoad) && !full && !rst_i;
    assign transfer   = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StLoad;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (transfer) begin
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_WIDTH-1:0];
                        wdata_d = DATA_WIDTH'(enc_word);
                        count_d = count_q + 1'b1;
                    end
                    if (!enc_illegal && (count_q == LastAddr)) begin
                        state_d = StDone;
                    end else if (in_last_i) begin
`ifdef MIPS_LOADER_NOP_PAD_EN
                        state_d = StPad;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
`ifdef MIPS_LOADER_NOP_PAD_EN
            StPad: begin
                // All-zero word is sll $0,$0,0
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_WIDTH-1:0];
                wdata_d = '0;
                count_d = count_q + 1'b1;
                if (count_q == LastAddr) begin
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // A write already registered must not reach memory in the cycle reset is asserted.
    assign imem_we_o    = we_q && !rst_i;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign count_o      = count_q;
    assign err_o        = err_q;
    // Done waits out the final write pulse so it rises the cycle after it.
    assign done_o       = (state_q == StDone) && !we_q;

endmodule
